insa_bounds_unit: RTL



---
 rtl/ariane_pkg.sv | 28 ++
 rtl/insa_bound_table.sv | 70 +++++++
 rtl/insa_bounds_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared execute-stage types for the INSA bounds extension: operator encoding,
// bound record layout and the bounds-unit control states.
package ariane_pkg;

    localparam int unsigned INSA_ADDR_W = 32;

    typedef enum logic [2:0] {
        INSA_SET,
        INSA_FIRST,
        INSA_LAST,
        INSA_CHECK,
        INSA_RSTBUF,
        INSA_ENCRASH,
        INSA_DISCRASH
    } insa_op_e;

    typedef struct packed {
        logic                   valid;
        logic [INSA_ADDR_W-1:0] base;
        logic [INSA_ADDR_W-1:0] last;
    } insa_bound_t;

    typedef enum logic {
        INSA_IDLE,
        INSA_SWEEP
    } insa_state_e;

endpackage

// File: rtl/insa_bound_table.sv
// Bound record storage: one write port, one combinational read port, and the
// sweep counter that clears one record per cycle while sweep_en_i is high.
module insa_bound_table #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned IDX_W      = $clog2(NR_ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sweep_clr_i,
    input  logic              sweep_en_i,
    output logic              sweep_last_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [ADDR_W-1:0] wbase_i,
    input  logic [ADDR_W-1:0] wlast_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic              rd_valid_o,
    output logic [ADDR_W-1:0] rd_base_o,
    output logic [ADDR_W-1:0] rd_last_o
);

    // Same layout as ariane_pkg::insa_bound_t, at this instance's bound width.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] last;
    } bound_t;

    localparam logic [IDX_W:0] NR_EXT = (IDX_W+1)'(NR_ENTRIES);

    bound_t           mem_q [NR_ENTRIES];
    bound_t           rd_entry;
    logic [IDX_W-1:0] cnt_q;
    logic             waddr_ok;
    logic             raddr_ok;

    assign waddr_ok     = {1'b0, waddr_i} < NR_EXT;
    assign raddr_ok     = {1'b0, raddr_i} < NR_EXT;
    assign sweep_last_o = (cnt_q == IDX_W'(NR_ENTRIES - 1));

    // The counter parks on the last entry; only a new sweep restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i || sweep_clr_i) begin
            cnt_q <= '0;
        end else if (sweep_en_i && !sweep_last_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (sweep_en_i) begin
            mem_q[cnt_q] <= '0;
        end else if (we_i && waddr_ok) begin
            mem_q[waddr_i] <= '{valid: 1'b1, base: wbase_i, last: wlast_i};
        end
    end

    always_comb begin
        rd_entry = '0;
        if (raddr_ok) begin
            rd_entry = mem_q[raddr_i];
        end
    end

    assign rd_valid_o = rd_entry.valid;
    assign rd_base_o  = rd_entry.base;
    assign rd_last_o  = rd_entry.last;

endmodule

// File: rtl/insa_bounds_unit.sv
// INSA bounds unit: executes the buffer-bound operators against a table of
// base/last records and raises a crash request on out-of-bounds checks.
module insa_bounds_unit
    import ariane_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned IDX_W      = $clog2(NR_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  insa_op_e         op_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [XLEN-1:0]  operand_a_i,
    input  logic [XLEN-1:0]  operand_b_i,
    output logic             valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic             violation_o,
    output logic             en_crash_o,
    output logic             crash_o
);

    // Handshake: an op is taken on a rising edge where valid_i && ready_o;
    // ready_o depends only on state, and results carry no backpressure.

    insa_state_e       state_q, state_d;
    logic              accept;
    logic              sweep_en;
    logic              sweep_clr;
    logic              sweep_last;
    logic              rstbuf_pending_q;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] rd_last;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              viol_cmp;
    logic [XLEN-1:0]   res_d;
    logic              viol_d;
    logic              unused_ok;

    assign accept    = valid_i && ready_o;
    assign a_addr    = operand_a_i[ADDR_W-1:0];
    assign b_addr    = operand_b_i[ADDR_W-1:0];
    assign unused_ok = ^{operand_a_i, operand_b_i};

    insa_bound_table #(
        .ADDR_W    (ADDR_W),
        .NR_ENTRIES(NR_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sweep_clr_i (sweep_clr),
        .sweep_en_i  (sweep_en),
        .sweep_last_o(sweep_last),
        .we_i        (accept && (op_i == INSA_SET)),
        .waddr_i     (idx_i),
        .wbase_i     (a_addr),
        .wlast_i     (b_addr),
        .raddr_i     (idx_i),
        .rd_valid_o  (rd_valid),
        .rd_base_o   (rd_base),
        .rd_last_o   (rd_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INSA_SWEEP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INSA_IDLE:  if (accept && (op_i == INSA_RSTBUF)) state_d = INSA_SWEEP;
            INSA_SWEEP: if (sweep_last) state_d = INSA_IDLE;
            default:    state_d = INSA_SWEEP;
        endcase
    end

    always_comb begin
        ready_o   = (state_q == INSA_IDLE);
        sweep_en  = (state_q == INSA_SWEEP);
        sweep_clr = accept && (op_i == INSA_RSTBUF);
    end

    // Invalid (including out-of-range) entries read as all-zero, never violate.
    assign viol_cmp = rd_valid && ((a_addr < rd_base) || (a_addr > rd_last));

    always_comb begin
        res_d  = '0;
        viol_d = 1'b0;
        case (op_i)
            INSA_FIRST: res_d = rd_valid ? XLEN'(rd_base) : '0;
            INSA_LAST:  res_d = rd_valid ? XLEN'(rd_last) : '0;
            INSA_CHECK: begin
                viol_d = viol_cmp;
                res_d  = XLEN'(viol_cmp);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o          <= 1'b0;
            result_o         <= '0;
            violation_o      <= 1'b0;
            crash_o          <= 1'b0;
            en_crash_o       <= 1'b0;
            rstbuf_pending_q <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            result_o    <= '0;
            violation_o <= 1'b0;
            crash_o     <= 1'b0;
            if (accept && (op_i != INSA_RSTBUF)) begin
                valid_o     <= 1'b1;
                result_o    <= res_d;
                violation_o <= viol_d;
                crash_o     <= viol_d && en_crash_o;
            end
            if (accept && (op_i == INSA_ENCRASH)) en_crash_o <= 1'b1;
            if (accept && (op_i == INSA_DISCRASH)) en_crash_o <= 1'b0;
            // RSTBUF completes once its own sweep clears the last entry.
            if (accept && (op_i == INSA_RSTBUF)) begin
                rstbuf_pending_q <= 1'b1;
            end else if (sweep_en && sweep_last && rstbuf_pending_q) begin
                rstbuf_pending_q <= 1'b0;
                valid_o          <= 1'b1;
            end
        end
    end

endmodule
